fmul_issue_arbiter: RTL and testbench

- Shares one fixed-latency, non-stallable fmul pipeline between NUM_REQ requesters.
- Grants one operand pair per cycle using round-robin priority.
- Tracks each issued operation in a valid/ID shift register and routes the result back to the requester that issued it.
- Sits between the scalar issue ports and the single multiplier instance.

---
 rtl/fmul_pkg.sv | 15 +
 rtl/fmul_issue_arbiter_rr_arbiter.sv | 43 ++++
 rtl/fmul_issue_arbiter.sv | 159 +++++++++++++++
 tb/tb_fmul_issue_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmul_pkg.sv
// Shared types and constants for the fmul issue arbiter and other FPU sharers.
package fmul_pkg;

    localparam int FP_W         = 32;
    localparam int FMUL_LATENCY = 4;
    localparam int TAG_ID_W     = 3;

    typedef logic [FP_W-1:0] fp32_t;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } arb_tag_t;

endpackage

// File: rtl/fmul_issue_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at i_ptr and wraps modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic [NUM_REQ-1:0]         o_grant,
    output logic [$clog2(NUM_REQ)-1:0] o_idx,
    output logic                       o_valid
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] w_sum;
    logic [IDX_W-1:0] w_cand;

    // First requesting index at or after the pointer wins; ptr < NUM_REQ so one wrap suffices.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_sum   = '0;
        w_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, i_ptr} + SUM_W'(k);
            if (w_sum >= SUM_W'(NUM_REQ)) begin
                w_sum = w_sum - SUM_W'(NUM_REQ);
            end else begin
                w_sum = w_sum;
            end
            w_cand = w_sum[IDX_W-1:0];
            if (!o_valid && i_req[w_cand]) begin
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
                o_valid         = 1'b1;
            end else begin
                o_valid = o_valid;
            end
        end
    end

endmodule

// File: rtl/fmul_issue_arbiter.sv
// Round-robin sharing of one fixed-latency fmul pipeline with result routing by tag.
// Optional performance counters are built when FMUL_ARB_PERF_EN is defined.
module fmul_issue_arbiter
    import fmul_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = FMUL_LATENCY
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    input  logic [NUM_REQ*FP_W-1:0] req_a_i,
    input  logic [NUM_REQ*FP_W-1:0] req_b_i,
    output logic [FP_W-1:0]         mul_operand_a_o,
    output logic [FP_W-1:0]         mul_operand_b_o,
    input  logic [FP_W-1:0]         mul_result_i,
    output logic [NUM_REQ-1:0]      resp_valid_o,
    output logic [FP_W-1:0]         resp_result_o,
    output logic                    busy_o
`ifdef FMUL_ARB_PERF_EN
    ,
    input  logic                    perf_clr_i,
    output logic [31:0]             perf_issue_cnt_o,
    output logic [31:0]             perf_conflict_cnt_o
`endif
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    logic [ID_W-1:0]    r_rr_ptr;
    fp32_t              r_op_a;
    fp32_t              r_op_b;
    arb_tag_t           r_tag [0:MUL_LATENCY];
    logic [NUM_REQ-1:0] r_resp_valid;
    fp32_t              r_resp_result;

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_idx;
    logic               w_any;
    logic               w_xfer;
    logic               w_resp_fire;
    logic [NUM_REQ-1:0] w_resp_vec;
    logic               w_busy;
    fp32_t              w_sel_a;
    fp32_t              w_sel_b;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .i_req   (req_valid_i),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_valid (w_any)
    );

    // Flush and reset both suppress grants so nothing enters a pipe being discarded.
    always_comb begin
        w_xfer      = w_any & ~flush_i & rst_ni;
        req_ready_o = w_xfer ? w_grant : '0;
        w_sel_a     = req_a_i[FP_W*w_idx +: FP_W];
        w_sel_b     = req_b_i[FP_W*w_idx +: FP_W];
        w_resp_fire = r_tag[MUL_LATENCY].valid & ~flush_i;
        w_resp_vec  = ONE_HOT0 << r_tag[MUL_LATENCY].id;
    end

    // Busy while any tag stage holds a live operation.
    always_comb begin
        w_busy = 1'b0;
        for (int k = 0; k <= MUL_LATENCY; k++) begin
            w_busy = w_busy | r_tag[k].valid;
        end
    end

    // Pointer, operand register and tag pipe; idle cycles feed 0*0 to the multiplier.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            for (int k = 0; k <= MUL_LATENCY; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            if (w_xfer) begin
                r_rr_ptr <= (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + ID_W'(1);
                r_op_a   <= w_sel_a;
                r_op_b   <= w_sel_b;
            end else begin
                r_rr_ptr <= r_rr_ptr;
                r_op_a   <= '0;
                r_op_b   <= '0;
            end
            r_tag[0].valid <= w_xfer;
            r_tag[0].id    <= TAG_ID_W'(w_idx);
            for (int k = 1; k <= MUL_LATENCY; k++) begin
                r_tag[k].valid <= r_tag[k-1].valid & ~flush_i;
                r_tag[k].id    <= r_tag[k-1].id;
            end
        end
    end

    // Last tag stage lines up with mul_result_i; the response is one more register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_resp_valid  <= '0;
            r_resp_result <= '0;
        end else if (w_resp_fire) begin
            r_resp_valid  <= w_resp_vec;
            r_resp_result <= mul_result_i;
        end else begin
            r_resp_valid  <= '0;
            r_resp_result <= r_resp_result;
        end
    end

    assign mul_operand_a_o = r_op_a;
    assign mul_operand_b_o = r_op_b;
    assign resp_valid_o    = r_resp_valid;
    assign resp_result_o   = r_resp_result;
    assign busy_o          = w_busy;

`ifdef FMUL_ARB_PERF_EN
    logic [31:0] r_issue_cnt;
    logic [31:0] r_conflict_cnt;
    logic        w_conflict;

    assign w_conflict = ($countones(req_valid_i) > 1);

    // Saturating event counters; clear wins over increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_issue_cnt    <= 32'd0;
            r_conflict_cnt <= 32'd0;
        end else if (perf_clr_i) begin
            r_issue_cnt    <= 32'd0;
            r_conflict_cnt <= 32'd0;
        end else begin
            if (w_xfer && (r_issue_cnt != 32'hFFFF_FFFF)) begin
                r_issue_cnt <= r_issue_cnt + 32'd1;
            end else begin
                r_issue_cnt <= r_issue_cnt;
            end
            if (w_conflict && (r_conflict_cnt != 32'hFFFF_FFFF)) begin
                r_conflict_cnt <= r_conflict_cnt + 32'd1;
            end else begin
                r_conflict_cnt <= r_conflict_cnt;
            end
        end
    end

    assign perf_issue_cnt_o    = r_issue_cnt;
    assign perf_conflict_cnt_o = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_fmul_issue_arbiter.sv
// Self-checking bench for fmul_issue_arbiter: transaction-level model plus directed scenarios.
module tb_fmul_issue_arbiter;

    localparam int N = 4;
    localparam int L = 4;

    typedef struct {
        int          due;
        int          id;
        logic [31:0] res;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          flush = 1'b0;
    logic [3:0]    req_valid = 4'b0;
    logic [127:0]  req_a;
    logic [127:0]  req_b;
    logic [3:0]    req_ready;
    logic [31:0]   mul_a;
    logic [31:0]   mul_b;
    logic [31:0]   mul_res;
    logic [3:0]    resp_valid;
    logic [31:0]   resp_result;
    logic          busy;
    logic [31:0]   p [4];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    exp_t        q [$];
    exp_t        keep [$];
    int          nxt = 0;
    logic [31:0] m_op_a = 32'h0;
    logic [31:0] m_op_b = 32'h0;

    logic [31:0] a_tab [4] = '{32'h3F800000, 32'h3FC00000, 32'h40000000, 32'h40400000};
    logic [31:0] r_tab [4] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40C00000};
    int          exp_g [9] = '{3, 0, 1, 2, 3, 0, 1, 2, 3};

`ifdef FMUL_ARB_PERF_EN
    logic        perf_clr = 1'b0;
    logic [31:0] perf_issue;
    logic [31:0] perf_conflict;
`endif

    fmul_issue_arbiter #(.NUM_REQ(N), .MUL_LATENCY(L)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .flush_i         (flush),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_a_i         (req_a),
        .req_b_i         (req_b),
        .mul_operand_a_o (mul_a),
        .mul_operand_b_o (mul_b),
        .mul_result_i    (mul_res),
        .resp_valid_o    (resp_valid),
        .resp_result_o   (resp_result),
        .busy_o          (busy)
`ifdef FMUL_ARB_PERF_EN
        ,
        .perf_clr_i          (perf_clr),
        .perf_issue_cnt_o    (perf_issue),
        .perf_conflict_cnt_o (perf_conflict)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Normal-number fp32 multiply with truncation; exact for the operands used here.
    function automatic logic [31:0] fmul32(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          e;
        logic [47:0] ma;
        logic [47:0] mb;
        logic [47:0] m;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
        ma = {24'd0, 1'b1, a[22:0]};
        mb = {24'd0, 1'b1, b[22:0]};
        m  = ma * mb;
        e  = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (m[47]) begin
            e = e + 1;
            return {s, e[7:0], m[46:24]};
        end
        return {s, e[7:0], m[45:23]};
    endfunction

    // Four-register multiplier stand-in.
    always @(posedge clk) begin
        p[0] <= fmul32(mul_a, mul_b);
        p[1] <= p[0];
        p[2] <= p[1];
        p[3] <= p[2];
    end
    assign mul_res = p[3];

    function automatic int pick(input logic [3:0] v, input int from);
        for (int k = 0; k < N; k++) begin
            if (v[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    function automatic int enc(input logic [3:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[k]) return k;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction model: each grant yields one response L+2 cycles later; flush/reset drop all.
    always @(negedge clk) begin : model
        logic [3:0]  exp_rv;
        logic [31:0] exp_res;
        logic [31:0] exp_rdy;
        int          nb;
        int          gi;
        exp_t        e;
        if (!rst_ni) begin
            q.delete();
            nxt    = 0;
            m_op_a = 32'h0;
            m_op_b = 32'h0;
        end
        exp_rv  = 4'b0;
        exp_res = 32'h0;
        nb      = 0;
        foreach (q[k]) begin
            if (q[k].due == cyc) begin
                exp_rv[q[k].id] = 1'b1;
                exp_res = q[k].res;
            end
            if (cyc >= q[k].due - (L + 1) && cyc < q[k].due) nb++;
        end
        chk("m_resp_valid", {28'd0, resp_valid}, {28'd0, exp_rv});
        if (exp_rv != 4'b0) chk("m_resp_result", resp_result, exp_res);
        chk("m_busy", {31'd0, busy}, {31'd0, (nb != 0)});
        chk("m_op_a", mul_a, m_op_a);
        chk("m_op_b", mul_b, m_op_b);
        gi = (!rst_ni || flush) ? -1 : pick(req_valid, nxt);
        exp_rdy = (gi < 0) ? 32'd0 : (32'd1 << gi);
        chk("m_req_ready", {28'd0, req_ready}, exp_rdy);
        keep.delete();
        if (!flush) begin
            foreach (q[k]) if (q[k].due > cyc) keep.push_back(q[k]);
        end
        q = keep;
        if (gi >= 0) begin
            e.due  = cyc + L + 2;
            e.id   = gi;
            e.res  = fmul32(req_a[32*gi +: 32], req_b[32*gi +: 32]);
            q.push_back(e);
            m_op_a = req_a[32*gi +: 32];
            m_op_b = req_b[32*gi +: 32];
            nxt    = (gi + 1) % N;
        end else begin
            m_op_a = 32'h0;
            m_op_b = 32'h0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int found;
        int cnt;
        int first_t;
        int last_t;
        int nr;
        int g_seen [9];
        int rid [16];
        int rt [16];
        logic [31:0] rres [16];

        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = a_tab[i];
            req_b[32*i +: 32] = 32'h40000000;
            p[i] = 32'h0;
        end

        // Reset with every requester pending.
        req_valid = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_resp_valid", {28'd0, resp_valid}, 32'd0);
        chk("rst_result", resp_result, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_op_a", mul_a, 32'd0);

        // First op: 1.0 * 2.0 from requester 0.
        @(posedge clk); #1;
        rst_ni = 1'b1;
        req_valid = 4'b0001;
        @(negedge clk);
        chk("first_grant", {28'd0, req_ready}, 32'h1);
        k = 0;
        found = 0;
        while (k < 20 && found == 0) begin
            @(posedge clk); #1;
            req_valid = 4'b0000;
            @(negedge clk);
            k++;
            if (resp_valid != 4'b0) found = 1;
        end
        chk("first_latency", k, 32'd6);
        chk("first_resp_valid", {28'd0, resp_valid}, 32'h1);
        chk("first_result", resp_result, 32'h40000000);

        // Requester 2 alone for five cycles.
        cnt = 0; first_t = -1; last_t = -1;
        for (int i = 0; i < 18; i++) begin
            @(posedge clk); #1;
            req_valid = (i < 5) ? 4'b0100 : 4'b0000;
            @(negedge clk);
            if (i < 5) chk("solo_grant", {28'd0, req_ready}, 32'h4);
            if (resp_valid == 4'b0100) begin
                cnt++;
                if (first_t < 0) first_t = i;
                last_t = i;
            end
        end
        chk("solo_resp_count", cnt, 32'd5);
        chk("solo_resp_span", last_t - first_t, 32'd4);

        // All four valid: pointer left at 3, then strict rotation.
        nr = 0;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            req_valid = (i < 9) ? 4'b1111 : 4'b0000;
            @(negedge clk);
            if (i < 9) g_seen[i] = enc(req_ready);
            if (resp_valid != 4'b0 && nr < 16) begin
                rid[nr]  = enc(resp_valid);
                rres[nr] = resp_result;
                rt[nr]   = i;
                nr++;
            end
        end
        for (int i = 0; i < 9; i++) chk("rot_grant", g_seen[i], exp_g[i]);
        chk("rot_resp_count", nr, 32'd9);
        for (int i = 0; i < 9 && i < nr; i++) begin
            chk("rot_resp_id", rid[i], exp_g[i]);
            chk("rot_resp_result", rres[i], r_tab[exp_g[i]]);
            chk("rot_resp_spacing", rt[i] - rt[0], i);
        end

        // Three ops then flush with requester 1 asking.
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            req_valid = (i < 3) ? 4'b0001 : (i == 4) ? 4'b0010 : 4'b0000;
            flush = (i == 4);
            @(negedge clk);
            if (i < 3) chk("flush_issue_grant", {28'd0, req_ready}, 32'h1);
            if (i == 4) begin
                chk("flush_ready", {28'd0, req_ready}, 32'd0);
                chk("flush_busy_before", {31'd0, busy}, 32'd1);
            end
            if (i == 5) chk("flush_busy_after", {31'd0, busy}, 32'd0);
            if (resp_valid != 4'b0) cnt++;
        end
        chk("flush_no_resp", cnt, 32'd0);

        // Two ops in flight, then asynchronous reset.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            req_valid = (i < 2) ? 4'b1000 : 4'b0000;
        end
        @(posedge clk); #3;
        rst_ni = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_resp_valid", {28'd0, resp_valid}, 32'd0);
        chk("arst_result", resp_result, 32'd0);
        chk("arst_op_a", mul_a, 32'd0);
        chk("arst_op_b", mul_b, 32'd0);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (resp_valid != 4'b0) cnt++;
            @(posedge clk); #1;
        end
        chk("arst_no_resp", cnt, 32'd0);

`ifdef FMUL_ARB_PERF_EN
        // Ten transfers, four of them contended, then clear.
        for (int i = 0; i < 13; i++) begin
            req_valid = (i < 6) ? 4'b0001 : (i < 10) ? 4'b0011 : 4'b0000;
            perf_clr  = (i == 11);
            @(negedge clk);
            if (i == 11) begin
                chk("perf_issue", perf_issue, 32'd10);
                chk("perf_conflict", perf_conflict, 32'd4);
            end
            if (i == 12) begin
                chk("perf_issue_clr", perf_issue, 32'd0);
                chk("perf_conflict_clr", perf_conflict, 32'd0);
            end
            @(posedge clk); #1;
        end
        perf_clr = 1'b0;
`endif

        req_valid = 4'b0000;
        repeat (10) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
